// File: rtl/knn_ctrl_if.sv
// -----------------------------------------------------------------------------
// knn_ctrl_if
// Bundles the signals between a k-nearest-neighbour controller and the logic
// that drives it: run control, the query point, the training-point stream
// handshake and the sorted result list.
//
// Signals (direction given from the controller's side, modport "slave"):
//   start            in   begin a classification run (honoured only when idle)
//   test_x, test_y   in   query point, captured on start
//   n_points         in   number of training points in the run
//   pt_valid         in   training point presented
//   pt_ready         out  controller accepts a point this cycle
//   pt_x, pt_y       in   training point coordinates
//   pt_label         in   training point class
//   busy             out  run in progress
//   done             out  one-cycle pulse at end of run
//   nn_dist          out  K packed distances, entry 0 (nearest) in the LSBs
//   nn_label         out  K packed labels aligned with nn_dist
//   nn_count         out  number of valid entries
//   class_label      out  majority class (only when KNN_VOTE_EN is defined)
//
// Optional feature macro: KNN_VOTE_EN adds class_label.
// -----------------------------------------------------------------------------
interface knn_ctrl_if #(
   parameter int K  = 4,
   parameter int DW = 16,
   parameter int LW = 8,
   parameter int NW = 16
);
   localparam int CW = $clog2(K + 1);

   logic                    start;
   logic [DW-1:0]           test_x;
   logic [DW-1:0]           test_y;
   logic [NW-1:0]           n_points;
   logic                    pt_valid;
   logic                    pt_ready;
   logic [DW-1:0]           pt_x;
   logic [DW-1:0]           pt_y;
   logic [LW-1:0]           pt_label;
   logic                    busy;
   logic                    done;
   logic [K*(2*DW+1)-1:0]   nn_dist;
   logic [K*LW-1:0]         nn_label;
   logic [CW-1:0]           nn_count;
`ifdef KNN_VOTE_EN
   logic [LW-1:0]           class_label;

   modport master (
      output start, test_x, test_y, n_points, pt_valid, pt_x, pt_y, pt_label,
      input  pt_ready, busy, done, nn_dist, nn_label, nn_count, class_label
   );

   modport slave (
      input  start, test_x, test_y, n_points, pt_valid, pt_x, pt_y, pt_label,
      output pt_ready, busy, done, nn_dist, nn_label, nn_count, class_label
   );
`else
   modport master (
      output start, test_x, test_y, n_points, pt_valid, pt_x, pt_y, pt_label,
      input  pt_ready, busy, done, nn_dist, nn_label, nn_count
   );

   modport slave (
      input  start, test_x, test_y, n_points, pt_valid, pt_x, pt_y, pt_label,
      output pt_ready, busy, done, nn_dist, nn_label, nn_count
   );
`endif
endinterface

// File: rtl/knn_ctrl.sv
// -----------------------------------------------------------------------------
// knn_ctrl
// Streams training points past a captured query point, computes the exact
// squared Euclidean distance of each, and keeps a sorted list of the K nearest
// (distance + label). A three-stage pipeline (difference, distance, insert)
// accepts one point per cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   knn_ctrl_if.slave: start/query/n_points, point stream handshake,
//         busy/done status and the result list (see knn_ctrl_if.sv)
//
// Optional feature macro: KNN_VOTE_EN adds a VOTE state that registers the
// majority label of the valid entries into class_label before done, adding
// one cycle of done latency.
// -----------------------------------------------------------------------------
module knn_ctrl #(
   parameter int K  = 4,
   parameter int DW = 16,
   parameter int LW = 8,
   parameter int NW = 16
) (
   input logic          clk,
   input logic          rst,
   knn_ctrl_if.slave    bus
);
   localparam int DDW = 2*DW + 1;
   localparam int CW  = $clog2(K + 1);

`ifdef KNN_VOTE_EN
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_VOTE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
`endif

   state_t                r_state;
   logic [DW-1:0]         r_test_x;
   logic [DW-1:0]         r_test_y;
   logic [NW-1:0]         r_n_points;
   logic [NW-1:0]         r_acc_cnt;
   logic                  r_pt_ready;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_drain_arm;

   // pipeline stage 1: differences, stage 2: distance
   logic                  r_s1_valid;
   logic signed [DW:0]    r_dx;
   logic signed [DW:0]    r_dy;
   logic [LW-1:0]         r_s1_label;
   logic                  r_s2_valid;
   logic [DDW-1:0]        r_s2_dist;
   logic [LW-1:0]         r_s2_label;

   // sorted result list, entry 0 nearest
   logic [DDW-1:0]        r_dist  [K];
   logic [LW-1:0]         r_label [K];
   logic [CW-1:0]         r_count;

   logic                  w_accept;
   logic                  w_last_accept;
   logic                  w_run_start;
   logic signed [DDW-1:0] w_dx_ext;
   logic signed [DDW-1:0] w_dy_ext;
   logic [DDW-1:0]        w_sq_x;
   logic [DDW-1:0]        w_sq_y;
   logic [DDW-1:0]        w_dist;
   logic [K-1:0]          w_gt;
   logic [DDW-1:0]        w_new_dist  [K];
   logic [LW-1:0]         w_new_label [K];
   logic [K*DDW-1:0]      w_nn_dist;
   logic [K*LW-1:0]       w_nn_label;

   assign w_accept      = r_pt_ready & bus.pt_valid;
   assign w_last_accept = w_accept && ((r_acc_cnt + NW'(1)) == r_n_points);
   assign w_run_start   = (r_state == S_IDLE) && bus.start;

   // Sign-extend to the full result width so the square is computed exactly
   // at DDW bits; |diff|^2 < 2^(2*DW) so nothing is lost in the product.
   assign w_dx_ext = {{DW{r_dx[DW]}}, r_dx};
   assign w_dy_ext = {{DW{r_dy[DW]}}, r_dy};
   assign w_sq_x   = w_dx_ext * w_dx_ext;
   assign w_sq_y   = w_dy_ext * w_dy_ext;
   assign w_dist   = w_sq_x + w_sq_y;

   // Insertion network. The list is sorted, so w_gt is a thermometer code: the
   // new entry lands at the first strictly greater slot (ties stay behind the
   // older entry) and everything after it moves one place toward K-1. Empty
   // slots hold all-ones, which exceeds any reachable distance.
   genvar gi;
   for (gi = 0; gi < K; gi++) begin : g_ins
      assign w_gt[gi] = r_dist[gi] > r_s2_dist;
      if (gi == 0) begin : g_head
         assign w_new_dist[gi]  = w_gt[gi] ? r_s2_dist  : r_dist[gi];
         assign w_new_label[gi] = w_gt[gi] ? r_s2_label : r_label[gi];
      end else begin : g_body
         assign w_new_dist[gi]  = !w_gt[gi]    ? r_dist[gi]    :
                                  w_gt[gi-1]   ? r_dist[gi-1]  : r_s2_dist;
         assign w_new_label[gi] = !w_gt[gi]    ? r_label[gi]   :
                                  w_gt[gi-1]   ? r_label[gi-1] : r_s2_label;
      end
      assign w_nn_dist[gi*DDW +: DDW] = r_dist[gi];
      assign w_nn_label[gi*LW +: LW]  = r_label[gi];
   end

`ifdef KNN_VOTE_EN
   logic [LW-1:0] r_class_label;
   logic [CW-1:0] w_votes [K];
   logic [CW-1:0] w_best_cnt;
   logic [LW-1:0] w_vote_label;

   for (gi = 0; gi < K; gi++) begin : g_vote
      logic [CW-1:0] w_v;
      always_comb begin
         w_v = '0;
         for (int j = 0; j < K; j++) begin
            if ((CW'(j) < r_count) && (r_label[j] == r_label[gi]))
               w_v = w_v + 1'b1;
         end
      end
      assign w_votes[gi] = w_v;
   end

   // Scanning from entry 0 with a strict compare keeps the first (best-ranked)
   // holder of the top count, which settles ties toward the nearest label.
   always_comb begin
      w_best_cnt   = '0;
      w_vote_label = '0;
      for (int i = 0; i < K; i++) begin
         if ((CW'(i) < r_count) && (w_votes[i] > w_best_cnt)) begin
            w_best_cnt   = w_votes[i];
            w_vote_label = r_label[i];
         end
      end
   end

   assign bus.class_label = r_class_label;
`endif

   // control FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_test_x    <= '0;
         r_test_y    <= '0;
         r_n_points  <= '0;
         r_acc_cnt   <= '0;
         r_pt_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_drain_arm <= 1'b0;
`ifdef KNN_VOTE_EN
         r_class_label <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_test_x    <= bus.test_x;
                  r_test_y    <= bus.test_y;
                  r_n_points  <= bus.n_points;
                  r_acc_cnt   <= '0;
                  r_busy      <= 1'b1;
                  r_drain_arm <= 1'b0;
                  if (bus.n_points == '0) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state    <= S_STREAM;
                     r_pt_ready <= 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (w_accept) begin
                  r_acc_cnt <= r_acc_cnt + NW'(1);
                  if (w_last_accept) begin
                     r_pt_ready  <= 1'b0;
                     r_drain_arm <= 1'b0;
                     r_state     <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // Stay at least one full cycle in DRAIN; with points in flight
               // the pipeline already forces that, and an empty run then
               // finishes on the second edge after start.
               r_drain_arm <= 1'b1;
               if (r_drain_arm && !r_s1_valid && !r_s2_valid) begin
`ifdef KNN_VOTE_EN
                  r_state <= S_VOTE;
`else
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
`endif
               end
            end
`ifdef KNN_VOTE_EN
            S_VOTE: begin
               r_class_label <= w_vote_label;
               r_done        <= 1'b1;
               r_busy        <= 1'b0;
               r_state       <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // distance pipeline and sorted list
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_dx       <= '0;
         r_dy       <= '0;
         r_s1_label <= '0;
         r_s2_valid <= 1'b0;
         r_s2_dist  <= '0;
         r_s2_label <= '0;
         r_count    <= '0;
         for (int i = 0; i < K; i++) begin
            r_dist[i]  <= '1;
            r_label[i] <= '0;
         end
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_dx       <= $signed({1'b0, bus.pt_x}) - $signed({1'b0, r_test_x});
            r_dy       <= $signed({1'b0, bus.pt_y}) - $signed({1'b0, r_test_y});
            r_s1_label <= bus.pt_label;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_dist  <= w_dist;
            r_s2_label <= r_s1_label;
         end
         if (w_run_start) begin
            r_count <= '0;
            for (int i = 0; i < K; i++) begin
               r_dist[i]  <= '1;
               r_label[i] <= '0;
            end
         end else if (r_s2_valid) begin
            for (int i = 0; i < K; i++) begin
               r_dist[i]  <= w_new_dist[i];
               r_label[i] <= w_new_label[i];
            end
            if (w_gt[K-1] && (r_count != CW'(K)))
               r_count <= r_count + 1'b1;
         end
      end
   end

   assign bus.pt_ready = r_pt_ready;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.nn_dist  = w_nn_dist;
   assign bus.nn_label = w_nn_label;
   assign bus.nn_count = r_count;
endmodule

// File: tb/tb_knn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_knn_ctrl
// Self-checking bench for knn_ctrl: directed scenarios (basic, tie, empty run,
// full-width distance, reset mid-run, stalled stream with stray start) plus
// randomized runs, all checked against a top-K reference computed by sorting.
// -----------------------------------------------------------------------------
module tb_knn_ctrl;
   localparam int K   = 4;
   localparam int DW  = 16;
   localparam int LW  = 8;
   localparam int NW  = 16;
   localparam int DDW = 2*DW + 1;
`ifdef KNN_VOTE_EN
   localparam int VX = 1;
`else
   localparam int VX = 0;
`endif
   localparam longint DMAX = (longint'(1) << DDW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   knn_ctrl_if #(.K(K), .DW(DW), .LW(LW), .NW(NW)) bus();

   knn_ctrl #(.K(K), .DW(DW), .LW(LW), .NW(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int     n_err = 0;
   int     n_chk = 0;
   int     q_x [16];
   int     q_y [16];
   int     q_l [16];
   longint exp_d [K];
   int     exp_l [K];
   int     exp_cnt;
   int     exp_cls;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic load(input int i, input int x, input int y, input int l);
      q_x[i] = x; q_y[i] = y; q_l[i] = l;
   endtask

   // Reference: stable selection of the K smallest distances, then a
   // label histogram for the vote.
   task automatic model(input int tx, input int ty, input int n);
      longint d [16];
      bit     used [16];
      int     cnt [int];
      int     best, bestc, l;
      for (int j = 0; j < 16; j++) used[j] = 1'b0;
      for (int j = 0; j < n; j++)
         d[j] = (longint'(q_x[j]) - tx) * (longint'(q_x[j]) - tx) +
                (longint'(q_y[j]) - ty) * (longint'(q_y[j]) - ty);
      for (int k = 0; k < K; k++) begin
         best = -1;
         for (int j = 0; j < n; j++)
            if (!used[j] && (best < 0 || d[j] < d[best])) best = j;
         if (best >= 0) begin
            used[best] = 1'b1;
            exp_d[k] = d[best];
            exp_l[k] = q_l[best];
         end else begin
            exp_d[k] = DMAX;
            exp_l[k] = 0;
         end
      end
      exp_cnt = (n < K) ? n : K;
      for (int k = 0; k < exp_cnt; k++) begin
         if (cnt.exists(exp_l[k])) cnt[exp_l[k]] = cnt[exp_l[k]] + 1;
         else cnt[exp_l[k]] = 1;
      end
      exp_cls = 0;
      bestc = 0;
      for (int k = 0; k < exp_cnt; k++) begin
         l = exp_l[k];
         if (cnt[l] > bestc) begin bestc = cnt[l]; exp_cls = l; end
      end
   endtask

   task automatic check_result(input string tag);
      for (int k = 0; k < K; k++) begin
         chk($sformatf("%s dist[%0d]", tag, k), 64'(bus.nn_dist[k*DDW +: DDW]), exp_d[k]);
         chk($sformatf("%s label[%0d]", tag, k), 64'(bus.nn_label[k*LW +: LW]), 64'(exp_l[k]));
      end
      chk({tag, " count"}, 64'(bus.nn_count), 64'(exp_cnt));
`ifdef KNN_VOTE_EN
      chk({tag, " class"}, 64'(bus.class_label), 64'(exp_cls));
`endif
   endtask

   // mode 0: valid every cycle, 1: valid every other cycle,
   // 2: random gaps plus junk presented while pt_ready should be low
   task automatic run(input string tag, input int tx, input int ty, input int n,
                      input int mode, input bit extra);
      int e, idx, last_acc, done_edge, done_cnt, extra_acc, it;
      bit rdy, ready_seen, gate;
      e = 0; idx = 0; last_acc = 0; done_edge = -1; done_cnt = 0;
      extra_acc = 0; ready_seen = 0;
      bus.test_x   = DW'(tx);
      bus.test_y   = DW'(ty);
      bus.n_points = NW'(n);
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
      it = 0;
      while (done_cnt == 0 && it < 300) begin
         case (mode)
            0:       gate = 1'b1;
            1:       gate = (it % 2 == 0);
            default: gate = ($urandom_range(0, 2) != 0);
         endcase
         bus.start = extra && (it == 3);
         if (bus.start) begin
            bus.test_x   = DW'($urandom_range(100, 900));
            bus.n_points = NW'(1);
         end
         if (idx < n && gate) begin
            bus.pt_valid = 1'b1;
            bus.pt_x     = DW'(q_x[idx]);
            bus.pt_y     = DW'(q_y[idx]);
            bus.pt_label = LW'(q_l[idx]);
         end else begin
            bus.pt_valid = (mode == 2) && (idx >= n);
            bus.pt_x     = DW'($urandom_range(0, 65535));
            bus.pt_y     = DW'($urandom_range(0, 65535));
            bus.pt_label = LW'($urandom_range(0, 255));
         end
         rdy = bus.pt_ready;
         if (rdy) ready_seen = 1'b1;
         @(posedge clk); e++; #1;
         if (bus.pt_valid && rdy) begin
            if (idx < n) begin idx++; last_acc = e; end
            else extra_acc++;
         end
         if (bus.done) begin done_cnt++; done_edge = e; end
         it++;
      end
      bus.pt_valid = 1'b0;
      bus.start    = 1'b0;
      chk({tag, " done_seen"}, 64'(done_cnt), 64'd1);
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.done) done_cnt++;
      end
      chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, " busy_after_done"}, 64'(bus.busy), 64'd0);
      chk({tag, " accepted"}, 64'(idx), 64'(n));
      chk({tag, " extra_accepts"}, 64'(extra_acc), 64'd0);
      if (n == 0) begin
         chk({tag, " ready_seen"}, 64'(ready_seen), 64'd0);
         chk({tag, " done_latency"}, 64'(done_edge), 64'(2 + VX));
      end else begin
         chk({tag, " done_latency"}, 64'(done_edge - last_acc), 64'(3 + VX));
      end
      model(tx, ty, n);
      check_result(tag);
      $display("run %s: n=%0d mode=%0d done_edge=%0d last_accept=%0d", tag, n, mode, done_edge, last_acc);
   endtask

   task automatic load_basic();
      load(0, 3, 4, 1);
      load(1, 1, 1, 2);
      load(2, 10, 0, 3);
      load(3, 0, 2, 4);
      load(4, 5, 5, 5);
   endtask

   initial begin
      int acc, n, tx, ty, lim;
      bit rdy;
      bus.start = 1'b0; bus.test_x = '0; bus.test_y = '0; bus.n_points = '0;
      bus.pt_valid = 1'b0; bus.pt_x = '0; bus.pt_y = '0; bus.pt_label = '0;

      // reset state
      #12;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset pt_ready", 64'(bus.pt_ready), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset count", 64'(bus.nn_count), 64'd0);
      chk("reset dist0", 64'(bus.nn_dist[0 +: DDW]), DMAX);
      chk("reset dist3", 64'(bus.nn_dist[3*DDW +: DDW]), DMAX);
`ifdef KNN_VOTE_EN
      chk("reset class", 64'(bus.class_label), 64'd0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;

      load_basic();
      run("basic", 0, 0, 5, 0, 1'b0);

      load(0, 1, 0, 7);
      load(1, 0, 1, 8);
      run("tie", 0, 0, 2, 0, 1'b0);

      run("empty", 0, 0, 0, 0, 1'b0);

      load(0, 65535, 65535, 9);
      run("width", 0, 0, 1, 0, 1'b0);
      chk("width literal", 64'(bus.nn_dist[0 +: DDW]), 64'h1_FFFC_0002);

      // reset in the middle of a run
      load_basic();
      bus.test_x = '0; bus.test_y = '0; bus.n_points = NW'(5); bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      acc = 0;
      for (int it = 0; it < 20 && acc < 2; it++) begin
         rdy = bus.pt_ready;
         bus.pt_valid = 1'b1;
         bus.pt_x = DW'(q_x[acc]); bus.pt_y = DW'(q_y[acc]); bus.pt_label = LW'(q_l[acc]);
         @(posedge clk); #1;
         if (rdy) acc++;
      end
      bus.pt_x = DW'(q_x[2]); bus.pt_y = DW'(q_y[2]); bus.pt_label = LW'(q_l[2]);
      #3 rst = 1'b0;
      #1;
      chk("midreset busy", 64'(bus.busy), 64'd0);
      chk("midreset pt_ready", 64'(bus.pt_ready), 64'd0);
      chk("midreset count", 64'(bus.nn_count), 64'd0);
      chk("midreset dist0", 64'(bus.nn_dist[0 +: DDW]), DMAX);
      bus.pt_valid = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      $display("run midreset: accepted %0d points before reset", acc);
      run("after_reset", 0, 0, 5, 0, 1'b0);

      run("flow", 0, 0, 5, 1, 1'b1);

      // randomized runs; small coordinate ranges provoke distance ties
      for (int r = 0; r < 8; r++) begin
         n   = $urandom_range(1, 10);
         lim = (r % 2 == 0) ? 15 : 65535;
         tx  = $urandom_range(0, lim);
         ty  = $urandom_range(0, lim);
         for (int j = 0; j < n; j++)
            load(j, $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(1, 3));
         run($sformatf("rand%0d", r), tx, ty, n, 2, r[0]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/knn_ctrl.md
KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The module SHALL provide the following parameters (name, default, meaning):
- K, 4, number of nearest neighbours kept.
- DW, 16, unsigned coordinate width.
- LW, 8, label width.
- NW, 16, point-count width.
REQ-003 The module SHALL provide the following ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, begin a classification run.
- test_x / test_y, in, DW each, query point; captured on start.
- n_points, in, NW, number of training points in the run; captured on start.
- pt_valid, in, 1, training point presented.
- pt_ready, out, 1, controller accepts a point this cycle.
- pt_x / pt_y, in, DW each, training point coordinates.
- pt_label, in, LW, training point class.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse at end of run.
- nn_dist, out, K*(2*DW+1), sorted distances; entry 0 is the nearest and occupies the LSBs.
- nn_label, out, K*LW, labels aligned with nn_dist.
- nn_count, out, clog2(K+1), number of valid entries.
- class_label, out, LW, majority class; present only with KNN_VOTE_EN.

Function
REQ-004 States SHALL be IDLE, STREAM, DRAIN, and VOTE (VOTE only with KNN_VOTE_EN).
REQ-005 In IDLE, start=1 SHALL perform all of the following:
- capture test_x, test_y and n_points;
- set every nn_dist entry to all-ones, every nn_label entry to 0, and nn_count to 0;
- zero the accept counter and set busy=1;
- enter STREAM, or DRAIN if n_points=0.
REQ-006 start SHALL be ignored in any state other than IDLE.
REQ-007 pt_ready SHALL be 1 only in STREAM; a point is accepted on any edge with pt_valid and pt_ready both 1, one point per cycle maximum.
REQ-008 pt_valid gaps SHALL stall the run without loss; inputs presented while pt_ready=0 SHALL be ignored.
REQ-009 When the accept count reaches n_points, pt_ready SHALL drop on the following cycle and the FSM SHALL enter DRAIN.
REQ-010 Distance SHALL be (pt_x-test_x)^2 + (pt_y-test_y)^2, computed exactly with signed DW+1-bit differences and a 2*DW+1-bit unsigned result, with no truncation or saturation.
REQ-011 The pipeline SHALL behave as follows:
- edge E0 (accept) registers the differences and the label;
- E1 registers the distance;
- E2 inserts the point into the list.
REQ-012 Insertion SHALL place the new entry before the first entry whose distance is strictly greater; that entry and all later entries shift toward index K-1, and entry K-1 is dropped.
REQ-013 On equal distances, the earlier-accepted point SHALL rank nearer.
REQ-014 A new distance not smaller than a full list's entry K-1 SHALL be discarded.
REQ-015 nn_count SHALL increment per insertion and saturate at K.
REQ-016 Without KNN_VOTE_EN, DRAIN SHALL wait until the pipeline is empty, then pulse done and clear busy on the edge after the last insertion, returning to IDLE.
REQ-017 With n_points=0, done SHALL pulse on the second edge after start.
REQ-018 nn_dist, nn_label, nn_count and class_label SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-019 rst=0 SHALL immediately force all of the following, regardless of state or in-flight points:
- state IDLE;
- busy=0, done=0, pt_ready=0;
- nn_count=0, all nn_dist entries all-ones, all nn_label entries 0, class_label 0;
- pipeline valid flags cleared.
REQ-020 After rst deasserts, the first start SHALL begin a clean run.

Configuration
REQ-021 Macro KNN_VOTE_EN defined: class_label SHALL exist, and DRAIN SHALL go to VOTE, which spends one cycle computing the majority class among the nn_count valid entries, registers it to class_label, then pulses done. Done latency is one cycle more than without the macro.
REQ-022 Vote ties SHALL resolve to the tied label whose best-ranked entry has the lowest index.
REQ-023 With nn_count=0, class_label SHALL be 0.
REQ-024 Macro KNN_VOTE_EN undefined: class_label and the VOTE state SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- Basic: K=4, test (0,0); points (3,4,L1),(1,1,L2),(10,0,L3),(0,2,L4),(5,5,L5), valid every cycle -> nn_dist {2,4,25,50}, nn_label {2,4,1,5}, nn_count 4; with KNN_VOTE_EN class_label 2.
- Tie: test (0,0); points (1,0,L7),(0,1,L8), n_points=2 -> nn_dist {1,1,all-ones,all-ones}, nn_label {7,8,0,0}, nn_count 2; done exactly 3 edges after the last accept (4 with KNN_VOTE_EN).
- Empty run: n_points=0 -> pt_ready never 1, done on the second edge after start, nn_count 0, dists all-ones.
- Width: test (0,0); point (65535,65535) -> nn_dist[0]=0x1FFFC0002.
- Reset mid-run: rst=0 after 2 of 5 points -> busy 0, pt_ready 0, nn_count 0 asynchronously; a new run then gives the Basic result.
- Flow: pt_valid toggled 1/0 and start pulsed while busy -> result identical to Basic; the extra start is ignored and exactly one done pulse occurs.
